// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer for the 64-bit HI/LO path.
// The datapath handles one bit per cycle: a shift-add multiplier or a
// restoring divider. Both work on operand magnitudes, and the signs are
// corrected in a single FIX cycle. A divide by zero goes straight to FIX
// with the result already loaded into the accumulator.
//
//   state | meaning
//   IDLE  | waiting for Start, Busy low
//   CALC  | one multiply/divide iteration per edge, WIDTH edges
//   FIX   | apply sign correction, register HI/LO
//   DONE  | Done/WE_R64 pulse for one cycle
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_we_r64,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand magnitudes and their sign flags. Signed ops are those with op[0] set.
  logic             w_a_neg, w_b_neg, w_b_zero;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_a_neg  = i_op[0] & i_a[WIDTH-1];
  assign w_b_neg  = i_op[0] & i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (WIDTH'(0) - i_a) : i_a;
  assign w_b_mag  = w_b_neg ? (WIDTH'(0) - i_b) : i_b;
  assign w_b_zero = (i_b == '0);

  // Multiply step: add the multiplicand into the upper half when the low bit is set, then shift right.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring divide step. The upper half holds the remainder; the lower half shifts the dividend out and the quotient in.
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_rem_sub;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge   = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_opb;
  assign w_div_next = {(w_div_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_div_ge};

  // Sign fix-up. The product is negated as one 2W value; the quotient and remainder are negated separately.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_fix_hi, w_fix_lo;
  assign w_prod   = r_neg_lo ? ((2*WIDTH)'(0) - r_acc) : r_acc;
  assign w_quo    = r_neg_lo ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_hi ? (WIDTH'(0) - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

  // Sequencer FSM together with the datapath registers and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_is_div <= i_op[1];
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_dbz    <= i_op[1] & w_b_zero;
            if (i_op[1] && w_b_zero) begin
              // The result is known now: HI = raw A, LO = all ones, no sign fix.
              r_acc    <= {i_a, {WIDTH{1'b1}}};
              r_neg_lo <= 1'b0;
              r_neg_hi <= 1'b0;
              r_state  <= S_FIX;
            end else if (i_op[1]) begin
              r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
              r_opb    <= w_b_mag;
              r_neg_lo <= w_a_neg ^ w_b_neg;
              r_neg_hi <= w_a_neg;
              r_state  <= S_CALC;
            end else begin
              r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
              r_opb    <= w_a_mag;
              r_neg_lo <= w_a_neg ^ w_b_neg;
              r_neg_hi <= 1'b0;
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_we_r64      = r_done;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer (WIDTH=32).
// Expected results come from 64-bit integer arithmetic on the operands.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, we, dbz;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_abort(abort), .o_busy(busy), .o_done(done), .o_we_r64(we),
    .o_hi(hi), .o_lo(lo), .o_div_by_zero(dbz)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural result of the four MIPS HI/LO operations.
  function automatic void model(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                                output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
    longint      sa, sb;
    logic [63:0] p;
    sa  = longint'($signed(aa));
    sb  = longint'($signed(bb));
    edz = 1'b0;
    p   = '0;
    case (o)
      2'd0: p = {32'b0, aa} * {32'b0, bb};
      2'd1: p = 64'(sa * sb);
      2'd2: if (bb == 0) begin p = {aa, 32'hFFFF_FFFF}; edz = 1'b1; end
            else p = {aa % bb, aa / bb};
      default: if (bb == 0) begin p = {aa, 32'hFFFF_FFFF}; edz = 1'b1; end
               else p = {32'(sa % sb), 32'(sa / sb)};
    endcase
    ehi = p[63:32];
    elo = p[31:0];
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("idle_before_start", {63'b0, busy}, 64'd0);
  endtask

  // Issue one op; optionally fire a second Start (different operands) before edge N+inj.
  task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input int inj, input string tag);
    int k, lat;
    bit hold_ok;
    wait_idle();
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    chk({tag, "_busy_after_start"}, {63'b0, busy}, 64'd1);
    lat = (o[1] && bb == 0) ? 1 : 33;
    k = 0; hold_ok = 1'b1;
    while (!done && k < 100) begin
      if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
      if (k + 1 == inj) begin start = 1'b1; a = 32'h1234_5678; b = 32'h0000_0000; op = 2'd3; end
      @(negedge clk);
      k++;
      if (k == inj) start = 1'b0;
    end
    chk({tag, "_latency"}, 64'(k), 64'(lat));
    chk({tag, "_hi"}, {32'b0, hi}, {32'b0, ehi});
    chk({tag, "_lo"}, {32'b0, lo}, {32'b0, elo});
    chk({tag, "_dbz"}, {63'b0, dbz}, {63'b0, edz});
    chk({tag, "_we"}, {63'b0, we}, 64'd1);
    chk({tag, "_hold"}, {63'b0, hold_ok}, 64'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {62'b0, done, we}, 64'd0);
    chk({tag, "_busy_end"}, {63'b0, busy}, 64'd0);
    prev_hi = ehi;
    prev_lo = elo;
  endtask

  // Start an op and abort it so that the abort is sampled at edge N+j.
  task automatic abort_at(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          input int j, input string tag);
    int k;
    bit seen;
    wait_idle();
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k + 1 < j) begin @(negedge clk); k++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk({tag, "_busy_after_abort"}, {63'b0, busy}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done || we) seen = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_no_done"}, {63'b0, seen}, 64'd0);
    chk({tag, "_hi_hold"}, {32'b0, hi}, {32'b0, prev_hi});
    chk({tag, "_lo_hold"}, {32'b0, lo}, {32'b0, prev_lo});
  endtask

  initial begin
    logic [31:0] ehi, elo;
    logic        edz;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          k;
    bit          seen;

    vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'd2, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{2'd2, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001, 32'h0000_0002, 1'b0};
    vecs[6]  = '{2'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[7]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{2'd3, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'd0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{2'd2, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000, 1'b0};
    vecs[11] = '{2'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, we, dbz, hi, lo}, 68'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 0,
             $sformatf("vec%0d", i));

    // A second Start while busy must be ignored.
    run_op(2'd0, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0000_000F, 1'b0, 5, "start_while_busy");

    // Abort in CALC, in FIX, and together with Start in IDLE.
    abort_at(2'd1, 32'h0000_1111, 32'h0000_2222, 10, "abort_calc");
    abort_at(2'd3, 32'h0000_0100, 32'h0000_0007, 33, "abort_fix");
    wait_idle();
    start = 1'b1; abort = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", {63'b0, busy}, 64'd0);
    seen = 1'b0;
    repeat (40) begin if (done) seen = 1'b1; @(negedge clk); end
    chk("abort_start_idle_no_done", {63'b0, seen}, 64'd0);

    // Asynchronous reset mid-CALC, after a divide by zero left Div_By_Zero and HI/LO nonzero.
    run_op(2'd2, 32'hABCD_0001, 32'h0, 32'hABCD_0001, 32'hFFFF_FFFF, 1'b1, 0, "pre_reset_dbz");
    wait_idle();
    start = 1'b1; op = 2'd0; a = 32'd12345; b = 32'd678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 6) begin @(negedge clk); k++; end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {busy, done, we, dbz, hi, lo}, 68'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_hi = '0; prev_lo = '0;
    run_op(2'd0, 32'd12345, 32'd678, 32'h0, 32'd8369910, 1'b0, 0, "after_reset");

    // Random operations checked against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(ro, ra, rb, ehi, elo, edz);
      run_op(ro, ra, rb, ehi, elo, edz, 0, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
